// File: rtl/des_key_schedule.sv
// des_key_schedule: DES round-key generator emitting K1..K16 (encrypt) or K16..K1 (decrypt), one per sk handshake.
// Ports: clk, rst_n (sync, active-low); key_valid/key_ready/key[63:0]/decrypt accept a key (key[63] = DES bit 1);
//   sk_valid/sk_ready/subkey[47:0]/round[3:0]/last deliver subkeys in emission order; busy while a schedule runs;
//   parity_err flags a key byte with even parity when DES_KS_PARITY_CHECK_EN is defined, otherwise tied to 0.
module des_key_schedule (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  output logic        key_ready,
  input  logic [63:0] key,
  input  logic        decrypt,
  output logic        sk_valid,
  input  logic        sk_ready,
  output logic [47:0] subkey,
  output logic [3:0]  round,
  output logic        last,
  output logic        busy,
  output logic        parity_err
);
  localparam int PC1 [56] = '{57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
                              10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
                              63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
                              14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int PC2 [48] = '{14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
                              23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
                              41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                              44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  typedef enum logic {IDLE, GEN} state_t;
  state_t      state_q, state_d;
  logic [27:0] c_q, c_d, d_q, d_d;
  logic [3:0]  round_q, round_d;
  logic        dir_q, dir_d;
  logic [55:0] cd0;
  logic [4:0]  sidx;
  logic        two;
  // DES bit p of the key lives at key[64-p]
  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) r[6'(55 - i)] = k[6'(64 - PC1[i])];
    return r;
  endfunction
  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int j = 0; j < 48; j++) r[6'(47 - j)] = cd[6'(56 - PC2[j])];
    return r;
  endfunction
  function automatic logic [27:0] rot(input logic [27:0] x, input logic right, input logic by2);
    return right ? (by2 ? {x[1:0], x[27:2]} : {x[0], x[27:1]})
                 : (by2 ? {x[25:0], x[27:26]} : {x[26:0], x[27]});
  endfunction
  assign cd0 = pc1(key);
  // shift-table index for the step to the next emitted key: s[round+2] forward, s[16-round] backward
  assign sidx = dir_q ? 5'd16 - {1'b0, round_q} : {1'b0, round_q} + 5'd2;
  assign two  = !(sidx == 5'd1 || sidx == 5'd2 || sidx == 5'd9 || sidx == 5'd16);
  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    d_d     = d_q;
    round_d = round_q;
    dir_d   = dir_q;
    if (state_q == IDLE) begin
      if (key_valid) begin
        state_d = GEN;
        dir_d   = decrypt;
        round_d = 4'd0;
        // decrypt starts at K16, whose C16/D16 equal C0/D0
        c_d     = decrypt ? cd0[55:28] : rot(cd0[55:28], 1'b0, 1'b0);
        d_d     = decrypt ? cd0[27:0]  : rot(cd0[27:0],  1'b0, 1'b0);
      end
    end else if (sk_ready) begin
      if (round_q == 4'd15) begin
        state_d = IDLE;
        round_d = 4'd0;
      end else begin
        round_d = round_q + 4'd1;
        c_d     = rot(c_q, dir_q, two);
        d_d     = rot(d_q, dir_q, two);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      c_q     <= '0;
      d_q     <= '0;
      round_q <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      round_q <= round_d;
      dir_q   <= dir_d;
    end
  end
`ifdef DES_KS_PARITY_CHECK_EN
  logic par_q, par_d;
  // every DES key byte should have odd parity
  always_comb begin
    par_d = par_q;
    if (state_q == IDLE && key_valid)
      par_d = ~&{^key[63:56], ^key[55:48], ^key[47:40], ^key[39:32],
                 ^key[31:24], ^key[23:16], ^key[15:8],  ^key[7:0]};
  end
  always_ff @(posedge clk) begin
    if (!rst_n) par_q <= 1'b0;
    else        par_q <= par_d;
  end
  assign parity_err = par_q;
`else
  logic unused_parity_bits;
  assign unused_parity_bits = ^{key[56], key[48], key[40], key[32], key[24], key[16], key[8], key[0]};
  assign parity_err = 1'b0;
`endif
  assign key_ready = (state_q == IDLE);
  assign sk_valid  = (state_q == GEN);
  assign busy      = (state_q == GEN);
  assign subkey    = pc2({c_q, d_q});
  assign round     = round_q;
  assign last      = sk_valid && round_q == 4'd15;
endmodule

// File: tb/tb_des_key_schedule.sv
// tb_des_key_schedule: directed bench for des_key_schedule with a transaction-level key-list model.
module tb_des_key_schedule;
  localparam int PC1 [56] = '{57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
                              10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
                              63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
                              14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int PC2 [48] = '{14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
                              23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
                              41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                              44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  localparam logic [63:0] K  = 64'h133457799BBCDFF1;
  localparam logic [47:0] K1 = 48'h1B02EFFC7072;
  localparam logic [47:0] K2 = 48'h79AED9DBC9E5;
  localparam logic [47:0] KF = 48'hCB3D8B0E17F5;
  logic clk = 0, rst_n = 0, key_valid = 0, decrypt = 0, sk_ready = 0;
  logic [63:0] key = '0;
  logic key_ready, sk_valid, last, busy, parity_err;
  logic [47:0] subkey;
  logic [3:0] round;
  int tests = 0, fails = 0, cyc = 0, acc = 0;
  bit chk_en = 0;
  des_key_schedule dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_ready(key_ready), .key(key),
    .decrypt(decrypt), .sk_valid(sk_valid), .sk_ready(sk_ready), .subkey(subkey),
    .round(round), .last(last), .busy(busy), .parity_err(parity_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // subkey list straight from the standard: Cn/Dn are C0/D0 rotated by the cumulative shift count
  function automatic logic [15:0][47:0] sched(input logic [63:0] k, input bit dec);
    logic [15:0][47:0] ks;
    logic [27:0] c0, d0, c, d;
    logic [55:0] cd;
    logic [47:0] sk;
    int tot;
    for (int i = 0; i < 28; i++) begin
      c0[27 - i] = k[64 - PC1[i]];
      d0[27 - i] = k[64 - PC1[i + 28]];
    end
    tot = 0;
    for (int r = 0; r < 16; r++) begin
      tot += SH[r];
      c = (c0 << tot) | (c0 >> (28 - tot));
      d = (d0 << tot) | (d0 >> (28 - tot));
      cd = {c, d};
      for (int j = 0; j < 48; j++) sk[47 - j] = cd[56 - PC2[j]];
      ks[dec ? 15 - r : r] = sk;
    end
    return ks;
  endfunction
`ifdef DES_KS_PARITY_CHECK_EN
  function automatic bit par_bad(input logic [63:0] k);
    bit bad = 0;
    for (int b = 0; b < 8; b++) if ($countones(k[8*b +: 8]) % 2 == 0) bad = 1;
    return bad;
  endfunction
`endif
  bit m_busy = 0, m_par = 0;
  int m_idx = 0;
  logic [15:0][47:0] m_keys = '0;
  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy <= 0;
      m_idx  <= 0;
      m_par  <= 0;
    end else if (!m_busy) begin
      if (key_valid) begin
        m_busy <= 1;
        m_idx  <= 0;
        m_keys <= sched(key, decrypt);
`ifdef DES_KS_PARITY_CHECK_EN
        m_par  <= par_bad(key);
`endif
      end
    end else if (sk_ready) begin
      m_busy <= (m_idx != 15);
      m_idx  <= (m_idx == 15) ? 0 : m_idx + 1;
    end
  end
  always @(negedge clk) if (chk_en) begin
    chk("sk_valid", sk_valid, m_busy);
    chk("key_ready", key_ready, !m_busy);
    chk("busy", busy, m_busy);
    chk("parity_err", parity_err, m_par);
    if (m_busy) begin
      chk("subkey", subkey, m_keys[m_idx]);
      chk("round", round, m_idx);
      chk("last", last, m_idx == 15);
    end else chk("last_idle", last, 0);
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic send_key(input logic [63:0] k, input bit dec);
    int n = 0;
    while (!key_ready && n < 100) begin
      tick;
      n++;
    end
    if (n >= 100) chk("key_ready_timeout", key_ready, 1);
    key = k;
    decrypt = dec;
    key_valid = 1;
    acc = cyc;
    tick;
    key_valid = 0;
  endtask
  task automatic collect(output logic [15:0][47:0] cap, input bit rnd);
    int hs = 0, n = 0;
    bit stall = 0;
    logic [47:0] psub = '0;
    logic [3:0] prnd = '0;
    cap = '0;
    while (hs < 16 && n < 400) begin
      if (rnd) begin
        sk_ready = 1'($urandom_range(0, 1));
        key_valid = ($urandom_range(0, 3) == 0);
        key = 64'hFEDCBA9876543210;
      end else sk_ready = 1;
      #3;
      if (stall) begin
        chk("hold_subkey", subkey, psub);
        chk("hold_round", round, prnd);
      end
      if (sk_valid && sk_ready) begin
        cap[round] = subkey;
        if (round == 4'd15) chk("last_at_15", last, 1);
        hs++;
      end
      stall = sk_valid && !sk_ready;
      psub = subkey;
      prnd = round;
      tick;
      n++;
    end
    key_valid = 0;
    sk_ready = 1;
    chk("handshakes", hs, 16);
  endtask
  logic [15:0][47:0] enc, dec, rk, c2, z, ks;
  initial begin
    tick;
    chk_en = 1;
    tick;
    rst_n = 1;
    chk("rst_sk_valid", sk_valid, 0);
    chk("rst_subkey", subkey, 0);
    chk("rst_last", last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_key_ready", key_ready, 1);
    chk("rst_round", round, 0);
    chk("rst_parity", parity_err, 0);
    ks = sched(K, 0);
    chk("model_k1", ks[0], K1);
    chk("model_k2", ks[1], K2);
    chk("model_k16", ks[15], KF);
    sk_ready = 1;
    send_key(K, 0);
    collect(enc, 0);
    chk("enc_k1", enc[0], K1);
    chk("enc_k2", enc[1], K2);
    chk("enc_k16", enc[15], KF);
    chk("ready_gap", cyc - acc, 17);
    chk("ready_back", key_ready, 1);
    send_key(K, 1);
    collect(dec, 0);
    chk("dec_r0", dec[0], KF);
    chk("dec_r15", dec[15], K1);
    for (int i = 0; i < 16; i++) chk("dec_reverse", dec[i], enc[15 - i]);
    send_key(K, 0);
    collect(rk, 1);
    for (int i = 0; i < 16; i++) chk("bp_seq", rk[i], enc[i]);
    tick;
    chk("bp_idle_busy", busy, 0);
    send_key(K, 0);
    for (int n = 0; n < 40 && round != 4'd7; n++) tick;
    chk("mid_round7", round, 7);
    rst_n = 0;
    tick;
    rst_n = 1;
    chk("midrst_sk_valid", sk_valid, 0);
    chk("midrst_round", round, 0);
    chk("midrst_key_ready", key_ready, 1);
    send_key(K, 0);
    collect(c2, 0);
    chk("restart_k1", c2[0], K1);
    chk("restart_k16", c2[15], KF);
    send_key(64'h0101010101010101, 0);
    collect(z, 0);
    for (int i = 0; i < 16; i++) chk("odd_key_zero", z[i], 0);
    chk("par_odd", parity_err, 0);
    send_key(64'h0000000000000000, 0);
    collect(z, 0);
    for (int i = 0; i < 16; i++) chk("zero_key_zero", z[i], 0);
`ifdef DES_KS_PARITY_CHECK_EN
    chk("par_zero", parity_err, 1);
`else
    chk("par_zero", parity_err, 0);
`endif
    tick;
    tick;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
